// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem SRAM controller: FSM encoding, lane count, mask expansion.
package dmem_pkg;

  localparam int MASK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [31:0] expand_mask(input logic [MASK_W-1:0] mask);
    logic [31:0] bits;
    bits = '0;
    for (int b = 0; b < MASK_W; b++) begin
      bits[8*b +: 8] = {8{mask[b]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Word storage: synchronous byte-masked write, synchronous registered read; contents are never reset.
module dmem_sram_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     idx,
  input  logic [31:0]       wdata,
  input  logic [MASK_W-1:0] mask,
  output logic [31:0]       q
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (mask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) q <= mem[idx];
  end

endmodule

// File: rtl/dmem_sram_ctrl.sv
// Multi-cycle data memory behind the hart dmem port: fixed LATENCY, one request in flight.
// Define DMEM_SRAM_PERF_EN to add saturating read/write/error/busy-cycle counters.
module dmem_sram_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_req_addr,
  input  logic              i_req_ren,
  input  logic              i_req_wen,
  input  logic [31:0]       i_req_wdata,
  input  logic [MASK_W-1:0] i_req_mask,
  output logic              o_req_ready,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_busy
`ifdef DMEM_SRAM_PERF_EN
  ,
  output logic [31:0]       o_perf_reads,
  output logic [31:0]       o_perf_writes,
  output logic [31:0]       o_perf_errs,
  output logic [31:0]       o_perf_busy_cycles
`endif
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  state_t            state;
  logic [3:0]        cnt;
  logic              ren_q, wen_q, err_q;
  logic [AW-1:0]     idx_q;
  logic [31:0]       wdata_q;
  logic [MASK_W-1:0] mask_q;
  logic [31:0]       q;

  // 33-bit offset so addresses below BASE_ADDR or past the top cannot wrap into range
  logic [32:0] off;
  logic        in_range, accept, do_op;

  assign off      = {1'b0, i_req_addr} - {1'b0, BASE_ADDR};
  assign in_range = (i_req_addr >= BASE_ADDR) && (off < SPAN);
  assign accept   = (state == IDLE) && (i_req_ren || i_req_wen);
  // Gating with reset guarantees a write interrupted by reset never commits
  assign do_op    = (state == WAIT) && (cnt == 4'd0) && i_rst_n;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ren_q <= 1'b0;
      wen_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= WAIT;
          cnt   <= 4'(LATENCY - 1);
          ren_q <= i_req_ren;
          wen_q <= i_req_wen;
          err_q <= (i_req_ren && i_req_wen) || !in_range;
        end
        WAIT: if (cnt != 4'd0) cnt <= cnt - 4'd1;
              else             state <= RESP;
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      idx_q   <= off[AW+1:2];
      wdata_q <= i_req_wdata;
      mask_q  <= i_req_mask;
    end
  end

  dmem_sram_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk   (i_clk),
    .we    (do_op && wen_q && !err_q),
    .re    (do_op && ren_q && !err_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .mask  (mask_q),
    .q     (q)
  );

  assign o_req_ready = (state == IDLE);
  assign o_busy      = (state != IDLE);
  assign o_rsp_valid = (state == RESP);
  assign o_rsp_err   = (state == RESP) && err_q;
  assign o_rsp_rdata = ((state == RESP) && ren_q && !err_q) ? (q & expand_mask(mask_q)) : 32'h0;

`ifdef DMEM_SRAM_PERF_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_perf_reads       <= '0;
      o_perf_writes      <= '0;
      o_perf_errs        <= '0;
      o_perf_busy_cycles <= '0;
    end else begin
      if (do_op && ren_q && !err_q && (o_perf_reads != '1))  o_perf_reads  <= o_perf_reads + 32'd1;
      if (do_op && wen_q && !err_q && (o_perf_writes != '1)) o_perf_writes <= o_perf_writes + 32'd1;
      if (do_op && err_q && (o_perf_errs != '1))             o_perf_errs   <= o_perf_errs + 32'd1;
      if (o_busy && (o_perf_busy_cycles != '1)) o_perf_busy_cycles <= o_perf_busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// Directed bench for dmem_sram_ctrl: three instances at LATENCY 2, 1 and 15.
module tb_dmem_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr  [3];
  logic        ren   [3];
  logic        wen   [3];
  logic [31:0] wdata [3];
  logic [3:0]  mask  [3];
  logic        rdy   [3];
  logic        vld   [3];
  logic [31:0] rdata [3];
  logic        err   [3];
  logic        busy  [3];
`ifdef DMEM_SRAM_PERF_EN
  logic [31:0] p_rd [3];
  logic [31:0] p_wr [3];
  logic [31:0] p_er [3];
  logic [31:0] p_bz [3];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_sram_ctrl #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_addr(addr[0]), .i_req_ren(ren[0]), .i_req_wen(wen[0]),
    .i_req_wdata(wdata[0]), .i_req_mask(mask[0]), .o_req_ready(rdy[0]), .o_rsp_valid(vld[0]),
    .o_rsp_rdata(rdata[0]), .o_rsp_err(err[0]), .o_busy(busy[0])
`ifdef DMEM_SRAM_PERF_EN
    , .o_perf_reads(p_rd[0]), .o_perf_writes(p_wr[0]), .o_perf_errs(p_er[0]), .o_perf_busy_cycles(p_bz[0])
`endif
  );

  dmem_sram_ctrl #(.DEPTH_WORDS(64), .LATENCY(1), .BASE_ADDR(32'h0)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_addr(addr[1]), .i_req_ren(ren[1]), .i_req_wen(wen[1]),
    .i_req_wdata(wdata[1]), .i_req_mask(mask[1]), .o_req_ready(rdy[1]), .o_rsp_valid(vld[1]),
    .o_rsp_rdata(rdata[1]), .o_rsp_err(err[1]), .o_busy(busy[1])
`ifdef DMEM_SRAM_PERF_EN
    , .o_perf_reads(p_rd[1]), .o_perf_writes(p_wr[1]), .o_perf_errs(p_er[1]), .o_perf_busy_cycles(p_bz[1])
`endif
  );

  dmem_sram_ctrl #(.DEPTH_WORDS(64), .LATENCY(15), .BASE_ADDR(32'h0)) dut15 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_addr(addr[2]), .i_req_ren(ren[2]), .i_req_wen(wen[2]),
    .i_req_wdata(wdata[2]), .i_req_mask(mask[2]), .o_req_ready(rdy[2]), .o_rsp_valid(vld[2]),
    .o_rsp_rdata(rdata[2]), .o_rsp_err(err[2]), .o_busy(busy[2])
`ifdef DMEM_SRAM_PERF_EN
    , .o_perf_reads(p_rd[2]), .o_perf_writes(p_wr[2]), .o_perf_errs(p_er[2]), .o_perf_busy_cycles(p_bz[2])
`endif
  );

  // Issue one request on instance s starting at a negedge; returns at the first negedge with ready high again.
  // lat = negedges after the accept edge until valid (-1 if never); low = negedges with ready low.
  task automatic do_req(input int s, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m,
                        output logic [31:0] rd, output logic er, output int lat, output int low);
    int k;
    lat = -1; low = 0; rd = '0; er = 1'b0; k = 0;
    while (rdy[s] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    ren[s] = r; wen[s] = w; addr[s] = a; wdata[s] = d; mask[s] = m;
    @(posedge clk);
    #1;
    ren[s] = 1'b0; wen[s] = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (vld[s] === 1'b1 && lat < 0) begin
        lat = i; rd = rdata[s]; er = err[s];
      end
      if (rdy[s] === 1'b1) break;
      low++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      addr[s] = '0; ren[s] = 1'b0; wen[s] = 1'b0; wdata[s] = '0; mask[s] = 4'hF;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (rdy[0] !== 1'b1)   begin n_fail++; $display("FAIL rst_ready: got %b exp 1", rdy[0]); end
    n_checks++; if (vld[0] !== 1'b0)   begin n_fail++; $display("FAIL rst_valid: got %b exp 0", vld[0]); end
    n_checks++; if (busy[0] !== 1'b0)  begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy[0]); end
    n_checks++; if (err[0] !== 1'b0)   begin n_fail++; $display("FAIL rst_err: got %b exp 0", err[0]); end
    n_checks++; if (rdata[0] !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h exp 0", rdata[0]); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int lat, low;
    do_req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, low);
    n_checks++; if (lat !== 3)        begin n_fail++; $display("FAIL wr_latency: got %0d exp 3", lat); end
    n_checks++; if (low !== 3)        begin n_fail++; $display("FAIL wr_ready_low: got %0d exp 3", low); end
    n_checks++; if (rd !== 32'h0)     begin n_fail++; $display("FAIL wr_rdata: got %h exp 0", rd); end
    n_checks++; if (er !== 1'b0)      begin n_fail++; $display("FAIL wr_err: got %b exp 0", er); end
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat, low);
    n_checks++; if (lat !== 3)        begin n_fail++; $display("FAIL rd_latency: got %0d exp 3", lat); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h exp deadbeef", rd); end
    n_checks++; if (er !== 1'b0)      begin n_fail++; $display("FAIL rd_err: got %b exp 0", er); end
    @(negedge clk);
    n_checks++; if (rdata[0] !== 32'h0) begin n_fail++; $display("FAIL rdata_clear: got %h exp 0", rdata[0]); end
  endtask

  task automatic test_byte_lane();
    logic [31:0] rd; logic er; int lat, low;
    do_req(0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat, low);
    do_req(0, 1'b0, 1'b1, 32'h20, 32'h00AA0000, 4'b0100, rd, er, lat, low);
    do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat, low);
    n_checks++; if (rd !== 32'h11AA3344) begin n_fail++; $display("FAIL lane_full: got %h exp 11aa3344", rd); end
    do_req(0, 1'b1, 1'b0, 32'h22, 32'h0, 4'b1100, rd, er, lat, low);
    n_checks++; if (rd !== 32'h11AA0000) begin n_fail++; $display("FAIL lane_upper: got %h exp 11aa0000", rd); end
    do_req(0, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat, low);
    n_checks++; if (er !== 1'b0)         begin n_fail++; $display("FAIL mask0_wr_err: got %b exp 0", er); end
    do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'b0000, rd, er, lat, low);
    n_checks++; if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL mask0_rd: got %h/%b exp 0/0", rd, er); end
    do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat, low);
    n_checks++; if (rd !== 32'h11AA3344) begin n_fail++; $display("FAIL mask0_nochange: got %h exp 11aa3344", rd); end
  endtask

  task automatic test_range_err();
    logic [31:0] rd; logic er; int lat, low;
    do_req(0, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat, low);
    do_req(0, 1'b0, 1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, rd, er, lat, low);
    do_req(0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'hF, rd, er, lat, low);
    n_checks++; if (er !== 1'b1)     begin n_fail++; $display("FAIL range_rd_err: got %b exp 1", er); end
    n_checks++; if (rd !== 32'h0)    begin n_fail++; $display("FAIL range_rd_data: got %h exp 0", rd); end
    n_checks++; if (lat !== 3)       begin n_fail++; $display("FAIL range_latency: got %0d exp 3", lat); end
    do_req(0, 1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, er, lat, low);
    n_checks++; if (er !== 1'b1)     begin n_fail++; $display("FAIL range_wr_err: got %b exp 1", er); end
    do_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat, low);
    n_checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin n_fail++; $display("FAIL range_word0: got %h/%b exp cafef00d/0", rd, er); end
    do_req(0, 1'b1, 1'b0, 32'hFFC, 32'h0, 4'hF, rd, er, lat, low);
    n_checks++; if (rd !== 32'h0BADF00D || er !== 1'b0) begin n_fail++; $display("FAIL last_word: got %h/%b exp 0badf00d/0", rd, er); end
  endtask

  task automatic test_illegal();
    logic [31:0] rd; logic er; int lat, low;
    do_req(0, 1'b1, 1'b1, 32'h0, 32'h12345678, 4'hF, rd, er, lat, low);
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL illegal_rsp: got %h/%b exp 0/1", rd, er); end
    n_checks++; if (low !== 3)   begin n_fail++; $display("FAIL illegal_ready_low: got %0d exp 3", low); end
    do_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat, low);
    n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL illegal_nowrite: got %h exp cafef00d", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat, low; int seen;
    do_req(0, 1'b0, 1'b1, 32'h8, 32'h0BADC0DE, 4'hF, rd, er, lat, low);
    addr[0] = 32'h8; wdata[0] = 32'h55555555; mask[0] = 4'hF; wen[0] = 1'b1;
    @(posedge clk);
    #1;
    wen[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (vld[0] === 1'b1) seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (vld[0] === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0)     begin n_fail++; $display("FAIL midrst_valid: got %0d strobes exp 0", seen); end
    n_checks++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b exp 1", rdy[0]); end
    do_req(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, lat, low);
    n_checks++; if (rd !== 32'h0BADC0DE) begin n_fail++; $display("FAIL midrst_nowrite: got %h exp 0badc0de", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat, low;
    for (int r = 0; r < 2; r++) begin
      do_req(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, rd, er, lat, low);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL l1_latency[%0d]: got %0d exp 2", r, lat); end
      n_checks++; if (low !== 2) begin n_fail++; $display("FAIL l1_ready_low[%0d]: got %0d exp 2", r, low); end
    end
    for (int r = 0; r < 2; r++) begin
      do_req(2, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, rd, er, lat, low);
      n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL l15_latency[%0d]: got %0d exp 16", r, lat); end
      n_checks++; if (low !== 16) begin n_fail++; $display("FAIL l15_ready_low[%0d]: got %0d exp 16", r, low); end
    end
`ifdef DMEM_SRAM_PERF_EN
    n_checks++; if (p_rd[1] !== 32'd2)  begin n_fail++; $display("FAIL l1_perf_reads: got %0d exp 2", p_rd[1]); end
    n_checks++; if (p_rd[2] !== 32'd2)  begin n_fail++; $display("FAIL l15_perf_reads: got %0d exp 2", p_rd[2]); end
    n_checks++; if (p_bz[1] !== 32'd4)  begin n_fail++; $display("FAIL l1_perf_busy: got %0d exp 4", p_bz[1]); end
    n_checks++; if (p_bz[2] !== 32'd32) begin n_fail++; $display("FAIL l15_perf_busy: got %0d exp 32", p_bz[2]); end
    n_checks++; if (p_wr[1] !== 32'd0 || p_er[1] !== 32'd0) begin n_fail++; $display("FAIL l1_perf_wr_err: got %0d/%0d exp 0/0", p_wr[1], p_er[1]); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lane();
    test_range_err();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
